// File: rtl/hdmi_in_capture.sv
// hdmi_in_capture
//   Receive side of the HDMI pixel port. It registers the raw sync, video-enable and
//   colour inputs once, then packs active pixels into 32-bit words for the DMA write
//   FIFO. Capture is frame-aligned: after enable it waits for a vsync active edge, so a
//   partial frame is never written. Active width and height are measured continuously
//   while enabled, and words dropped on a full FIFO are flagged.
//
//   Ports
//     clock_i                 pixel clock, rising edge
//     reset_i                 asynchronous active-high reset
//     enable_i                capture enable; low returns to IDLE and clears overflow
//     polarity_i              active level of hsync/vsync (1 = active-high)
//     num_bytes_per_pixel_i   1 = RGB888 (1 px/word), 0 = RGB565 (2 px/word)
//     red_i/green_i/blue_i    pixel components, meaningful while ve_i = 1
//     hsync_i/vsync_i         sync inputs (hsync is not needed for capture)
//     ve_i                    video enable, high on active pixels
//     fifo_full_i             downstream FIFO full
//     wr_data_o/wr_en_o       packed word and its single-cycle write strobe
//     frame_start_o           pulse on each vsync active edge while armed
//     line_end_o              pulse on each ve falling edge while capturing
//     overflow_o              sticky: a word was dropped on a full FIFO
//     hres_meas_o/vres_meas_o active pixels per line / active lines per frame
//     state_o                 FSM state (0 IDLE, 1 WAIT_VS, 2 ACTIVE)
//
//   Write interface: a word is offered on wr_data_o with wr_en_o high for exactly one
//   cycle. fifo_full_i is sampled in the cycle the word is formed (one clock before the
//   strobe would appear); if it is high the strobe is suppressed, the word is lost and
//   overflow_o is set. There is no back-pressure into the video source.
module hdmi_in_capture #(
   parameter int MAX_RES = 2047
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic        polarity_i,
   input  logic        num_bytes_per_pixel_i,
   input  logic [7:0]  red_i,
   input  logic [7:0]  green_i,
   input  logic [7:0]  blue_i,
   input  logic        hsync_i,
   input  logic        vsync_i,
   input  logic        ve_i,
   input  logic        fifo_full_i,
   output logic [31:0] wr_data_o,
   output logic        wr_en_o,
   output logic        frame_start_o,
   output logic        line_end_o,
   output logic        overflow_o,
   output logic [10:0] hres_meas_o,
   output logic [10:0] vres_meas_o,
   output logic [1:0]  state_o
);

   localparam logic [10:0] MAX_CNT = 11'(MAX_RES);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_VS = 2'd1,
      S_ACTIVE  = 2'd2
   } state_t;

   state_t      state_q, state_d;

   // input stage and the previous sample used for edge detection
   logic        ve_q, ve_prev_q;
   logic        vs_q, vs_prev_q;
   logic [23:0] rgb_q;

   // RGB565 packing
   logic        phase_q, phase_d;
   logic [15:0] held_q, held_d;

   // measurement
   logic [10:0] hcnt_q, hcnt_d;
   logic [10:0] vcnt_q, vcnt_d;
   logic [10:0] hres_q, hres_d;
   logic [10:0] vres_q, vres_d;

   // registered outputs
   logic [31:0] wr_data_q, wr_data_d;
   logic        wr_en_q, wr_en_d;
   logic        frame_start_q, frame_start_d;
   logic        line_end_q, line_end_d;
   logic        overflow_q, overflow_d;

   logic        vs_act;
   logic        ve_rise, ve_fall, vs_rise;
   logic        capturing, measuring;
   logic        phase_eff;
   logic [15:0] pix565;
   logic        want_wr;
   logic [31:0] word;
   logic [10:0] line_cnt;

   // hsync carries no information the capture needs; ve delimits lines.
   logic        unused_hsync;
   assign unused_hsync = hsync_i;

   function automatic logic [10:0] sat_inc(input logic [10:0] v);
      return (v >= MAX_CNT) ? v : v + 11'd1;
   endfunction

   always_comb begin
      vs_act    = (vsync_i == polarity_i);
      ve_rise   = ve_q & ~ve_prev_q;
      ve_fall   = ~ve_q & ve_prev_q;
      vs_rise   = vs_q & ~vs_prev_q;
      capturing = enable_i & (state_q == S_ACTIVE);
      measuring = (state_q != S_IDLE);
      pix565    = {rgb_q[23:19], rgb_q[15:10], rgb_q[7:3]};
      // a new line always starts on the even pixel
      phase_eff = phase_q & ~ve_rise;
   end

   // ---------------- FSM ----------------
   always_comb begin
      state_d = state_q;
      if (!enable_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    state_d = S_WAIT_VS;
            S_WAIT_VS: if (vs_rise) state_d = S_ACTIVE;
            S_ACTIVE:  state_d = S_ACTIVE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // ---------------- pixel packing ----------------
   always_comb begin
      want_wr = 1'b0;
      word    = 32'h0;
      phase_d = phase_q;
      held_d  = held_q;
      if (!capturing) begin
         // leaving capture discards any half-built RGB565 word
         phase_d = 1'b0;
      end else if (ve_q) begin
         if (num_bytes_per_pixel_i) begin
            want_wr = 1'b1;
            word    = {rgb_q, 8'h00};
            phase_d = 1'b0;
         end else if (!phase_eff) begin
            held_d  = pix565;
            phase_d = 1'b1;
         end else begin
            want_wr = 1'b1;
            word    = {pix565, held_q};
            phase_d = 1'b0;
         end
      end else if (ve_fall && phase_q) begin
         // odd-width line: flush the lone even pixel with an empty upper half
         want_wr = 1'b1;
         word    = {16'h0000, held_q};
         phase_d = 1'b0;
      end

      wr_en_d       = want_wr & ~fifo_full_i;
      wr_data_d     = wr_en_d ? word : wr_data_q;
      overflow_d    = enable_i & (overflow_q | (want_wr & fifo_full_i));
      frame_start_d = enable_i & vs_rise & (state_q != S_IDLE);
      line_end_d    = capturing & ve_fall;
   end

   // ---------------- measurement ----------------
   always_comb begin
      hcnt_d   = hcnt_q;
      vcnt_d   = vcnt_q;
      hres_d   = hres_q;
      vres_d   = vres_q;
      line_cnt = ve_fall ? sat_inc(vcnt_q) : vcnt_q;
      if (measuring) begin
         // the width counter restarts on the first pixel of each line
         if (ve_q) hcnt_d = ve_rise ? 11'd1 : sat_inc(hcnt_q);
         if (ve_fall) hres_d = hcnt_q;
         // a line ending in the same cycle as the vsync edge belongs to the old frame
         if (vs_rise) begin
            vres_d = line_cnt;
            vcnt_d = 11'd0;
         end else begin
            vcnt_d = line_cnt;
         end
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         ve_q          <= 1'b0;
         ve_prev_q     <= 1'b0;
         vs_q          <= 1'b0;
         vs_prev_q     <= 1'b0;
         rgb_q         <= 24'h0;
         phase_q       <= 1'b0;
         held_q        <= 16'h0;
         hcnt_q        <= 11'd0;
         vcnt_q        <= 11'd0;
         hres_q        <= 11'd0;
         vres_q        <= 11'd0;
         wr_data_q     <= 32'h0;
         wr_en_q       <= 1'b0;
         frame_start_q <= 1'b0;
         line_end_q    <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         ve_q          <= ve_i;
         ve_prev_q     <= ve_q;
         vs_q          <= vs_act;
         vs_prev_q     <= vs_q;
         rgb_q         <= {red_i, green_i, blue_i};
         phase_q       <= phase_d;
         held_q        <= held_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         hres_q        <= hres_d;
         vres_q        <= vres_d;
         wr_data_q     <= wr_data_d;
         wr_en_q       <= wr_en_d;
         frame_start_q <= frame_start_d;
         line_end_q    <= line_end_d;
         overflow_q    <= overflow_d;
      end
   end

   assign wr_data_o     = wr_data_q;
   assign wr_en_o       = wr_en_q;
   assign frame_start_o = frame_start_q;
   assign line_end_o    = line_end_q;
   assign overflow_o    = overflow_q;
   assign hres_meas_o   = hres_q;
   assign vres_meas_o   = vres_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_hdmi_in_capture.sv
// tb_hdmi_in_capture
//   Directed bench for hdmi_in_capture. A line/frame-level model tracks whether capture
//   is armed and pushes the words each driven line must produce into exp_q; one monitor
//   pops and compares on every write strobe. Literal checks pin latency, packing and the
//   measured resolutions.
module tb_hdmi_in_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable_i, polarity_i, nbpp_i;
   logic [7:0]  red_i, green_i, blue_i;
   logic        hsync_i, vsync_i, ve_i, fifo_full_i;
   logic [31:0] wr_data_o;
   logic        wr_en_o, frame_start_o, line_end_o, overflow_o;
   logic [10:0] hres_meas_o, vres_meas_o;
   logic [1:0]  state_o;

   hdmi_in_capture #(.MAX_RES(2047)) dut (
      .clock_i(clk), .reset_i(rst), .enable_i(enable_i), .polarity_i(polarity_i),
      .num_bytes_per_pixel_i(nbpp_i), .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
      .hsync_i(hsync_i), .vsync_i(vsync_i), .ve_i(ve_i), .fifo_full_i(fifo_full_i),
      .wr_data_o(wr_data_o), .wr_en_o(wr_en_o), .frame_start_o(frame_start_o),
      .line_end_o(line_end_o), .overflow_o(overflow_o), .hres_meas_o(hres_meas_o),
      .vres_meas_o(vres_meas_o), .state_o(state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5000000;
      $display("FAIL watchdog: time limit reached, expected end of test");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard / model state ----------------
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   int          got_cyc_q[$];
   int          n_checks = 0, n_fail = 0;
   int          n_fs = 0, n_le = 0, last_le_cyc = -1;
   int          exp_fs = 0, exp_le = 0;
   int          mdl_state = 0;   // 0 disabled, 1 armed waiting for vsync, 2 capturing
   int          mdl_lines = 0, mdl_hres = 0;
   bit          mdl_ovf = 0;
   int          line_start_cyc = 0;
   logic [23:0] line_rgb[0:2199];
   bit          full_mask[0:2199];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: got %0h expected no write (cycle %0d)", wr_data_o, cyc);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (wr_data_o !== e) begin
                  n_fail++;
                  $display("FAIL wr_data: got %0h expected %0h (cycle %0d)", wr_data_o, e, cyc);
               end
            end
            got_q.push_back(wr_data_o);
            got_cyc_q.push_back(cyc);
         end
         if (line_end_o) begin
            n_le++;
            last_le_cyc = cyc;
         end
         if (frame_start_o) n_fs++;
      end
   end

   // ---------------- driver helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] p565(input logic [23:0] c);
      return {c[23:19], c[15:10], c[7:3]};
   endfunction

   function automatic int sat(input int v);
      return (v > 2047) ? 2047 : v;
   endfunction

   task automatic set_enable(input logic v);
      enable_i = v;
      if (!v) begin
         mdl_state = 0;
         mdl_ovf   = 0;
      end else if (mdl_state == 0) begin
         mdl_state = 1;
      end
   endtask

   task automatic fill_line(input int n);
      for (int i = 0; i < n; i++) line_rgb[i] = 24'($urandom);
   endtask

   // vsync active edge as seen by the spec: arms/restarts capture, closes the frame
   task automatic model_vsync(output bit chk_vres);
      chk_vres = 0;
      if (mdl_state != 0) begin
         exp_fs++;
         if (mdl_state == 2) chk_vres = 1;
         mdl_state = 2;
      end
   endtask

   task automatic drive_vsync();
      bit chk;
      int lines;
      for (int c = 0; c < 6; c++) begin
         step();
         ve_i    = 1'b0;
         vsync_i = (c < 3) ? polarity_i : ~polarity_i;
      end
      lines = mdl_lines;
      model_vsync(chk);
      if (mdl_state != 0) mdl_lines = 0;
      step();
      if (chk) check("vres_meas", 32'(vres_meas_o), 32'(sat(lines)));
   endtask

   // One line of n active pixels from line_rgb. full_mask[c] drives fifo_full in the
   // c-th cycle of the line (word of pixel i is formed at c = i+1, an RGB565 pair with
   // odd pixel k at c = k+1, the odd-width flush at c = n+1).
   task automatic drive_line(input int n, input bit vs_at_end);
      bit chk;
      int lines;
      if (mdl_state == 2) begin
         if (nbpp_i) begin
            for (int i = 0; i < n; i++)
               if (full_mask[i+1]) mdl_ovf = 1;
               else exp_q.push_back({line_rgb[i], 8'h00});
         end else begin
            for (int k = 1; k < n; k += 2)
               if (full_mask[k+1]) mdl_ovf = 1;
               else exp_q.push_back({p565(line_rgb[k]), p565(line_rgb[k-1])});
            if (n % 2 == 1) begin
               if (full_mask[n+1]) mdl_ovf = 1;
               else exp_q.push_back({16'h0000, p565(line_rgb[n-1])});
            end
         end
         exp_le++;
      end
      if (mdl_state != 0) begin
         mdl_hres = sat(n);
         mdl_lines++;
      end
      for (int c = 0; c < n + 4; c++) begin
         step();
         if (c == 0) line_start_cyc = cyc;
         ve_i = (c < n);
         {red_i, green_i, blue_i} = (c < n) ? line_rgb[c] : 24'($urandom);
         fifo_full_i = full_mask[c];
         if (vs_at_end) vsync_i = (c >= n && c < n + 3) ? polarity_i : ~polarity_i;
      end
      fifo_full_i = 1'b0;
      for (int c = 0; c < n + 4; c++) full_mask[c] = 0;
      if (mdl_state != 0) check("hres_meas", 32'(hres_meas_o), 32'(mdl_hres));
      if (vs_at_end) begin
         lines = mdl_lines;
         model_vsync(chk);
         if (mdl_state != 0) mdl_lines = 0;
         if (chk) check("vres_meas_simul", 32'(vres_meas_o), 32'(sat(lines)));
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int fs_before, le_before;
      logic [15:0] px[0:4];
      px[0] = 16'hF800; px[1] = 16'h07E0; px[2] = 16'h001F; px[3] = 16'hFFFF; px[4] = 16'h1234;
      for (int i = 0; i < 2200; i++) full_mask[i] = 0;

      rst = 1'b1; enable_i = 1'b0; polarity_i = 1'b1; nbpp_i = 1'b1;
      red_i = 8'h00; green_i = 8'h00; blue_i = 8'h00;
      hsync_i = 1'b0; vsync_i = 1'b0; ve_i = 1'b0; fifo_full_i = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      check("rst_wr_data", wr_data_o, 32'h0);
      check("rst_wr_en", 32'(wr_en_o), 32'h0);
      check("rst_frame_start", 32'(frame_start_o), 32'h0);
      check("rst_line_end", 32'(line_end_o), 32'h0);
      check("rst_overflow", 32'(overflow_o), 32'h0);
      check("rst_hres", 32'(hres_meas_o), 32'h0);
      check("rst_vres", 32'(vres_meas_o), 32'h0);
      check("rst_state", 32'(state_o), 32'h0);

      // RGB888 frame of 6 lines x 8 pixels, enabled before vsync
      set_enable(1'b1);
      repeat (3) step();
      check("armed_state", 32'(state_o), 32'h1);
      drive_vsync();
      check("active_state", 32'(state_o), 32'h2);
      got_q.delete(); got_cyc_q.delete();
      fill_line(8);
      line_rgb[0] = 24'hA1B2C3;
      drive_line(8, 0);
      check("first_word", got_q[0], 32'hA1B2C300);
      check("first_word_latency", 32'(got_cyc_q[0] - line_start_cyc), 32'd2);
      check("words_per_line", 32'(got_q.size()), 32'd8);
      for (int l = 1; l < 6; l++) begin
         fill_line(8);
         drive_line(8, 0);
      end
      drive_vsync();
      check("vres_literal", 32'(vres_meas_o), 32'd6);
      check("hres_literal", 32'(hres_meas_o), 32'd8);

      // RGB565 odd-width line with hand-packed words and a flush at line end
      nbpp_i = 1'b0;
      for (int i = 0; i < 5; i++)
         line_rgb[i] = {px[i][15:11], 3'($urandom), px[i][10:5], 2'($urandom), px[i][4:0], 3'($urandom)};
      got_q.delete(); got_cyc_q.delete();
      drive_line(5, 0);
      check("rgb565_count", 32'(got_q.size()), 32'd3);
      if (got_q.size() == 3) begin
         check("rgb565_w0", got_q[0], 32'h07E0F800);
         check("rgb565_w1", got_q[1], 32'hFFFF001F);
         check("rgb565_flush", got_q[2], 32'h00001234);
         check("flush_with_line_end", 32'(got_cyc_q[2]), 32'(last_le_cyc));
      end
      check("rgb565_hres", 32'(hres_meas_o), 32'd5);
      fill_line(6); drive_line(6, 0);
      fill_line(7); drive_line(7, 0);

      // FIFO full for three words
      nbpp_i = 1'b1;
      fill_line(8);
      full_mask[3] = 1; full_mask[4] = 1; full_mask[5] = 1;
      got_q.delete(); got_cyc_q.delete();
      drive_line(8, 0);
      check("overflow_words", 32'(got_q.size()), 32'd5);
      check("overflow_set", 32'(overflow_o), 32'(mdl_ovf));
      fill_line(8); drive_line(8, 0);
      check("overflow_sticky", 32'(overflow_o), 32'h1);
      set_enable(1'b0);
      repeat (2) step();
      check("overflow_cleared", 32'(overflow_o), 32'h0);
      check("disabled_state", 32'(state_o), 32'h0);

      // enable dropped after the first RGB565 pixel of a line
      set_enable(1'b1);
      repeat (3) step();
      drive_vsync();
      nbpp_i = 1'b0;
      fill_line(6);
      got_q.delete(); got_cyc_q.delete();
      le_before = n_le;
      for (int c = 0; c < 10; c++) begin
         step();
         if (c == 2) set_enable(1'b0);
         ve_i = (c < 6);
         {red_i, green_i, blue_i} = line_rgb[c % 6];
      end
      check("drop_no_write", 32'(got_q.size()), 32'd0);
      check("drop_no_line_end", 32'(n_le), 32'(le_before));
      check("drop_state", 32'(state_o), 32'h0);

      // active-low syncs, enable mid-frame, saturation, vsync coinciding with line end
      polarity_i = 1'b0; vsync_i = 1'b1;
      repeat (2) step();
      set_enable(1'b1);
      nbpp_i = 1'b1;
      repeat (3) step();
      fs_before = n_fs;
      fill_line(2050); drive_line(2050, 0);
      check("hres_saturated", 32'(hres_meas_o), 32'd2047);
      fill_line(4); drive_line(4, 0);
      check("no_frame_start_midframe", 32'(n_fs), 32'(fs_before));
      drive_vsync();
      check("frame_start_at_vsync", 32'(n_fs), 32'(fs_before + 1));
      for (int l = 0; l < 2050; l++) begin
         fill_line(1); drive_line(1, 0);
      end
      drive_vsync();
      check("vres_saturated", 32'(vres_meas_o), 32'd2047);
      fill_line(3); drive_line(3, 0);
      fill_line(3); drive_line(3, 0);
      fill_line(3); drive_line(3, 1);
      check("vres_simul_literal", 32'(vres_meas_o), 32'd3);

      // reset in the middle of a captured RGB888 line
      fill_line(8);
      for (int i = 0; i < 8; i++) line_rgb[i][23] = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back({line_rgb[i], 8'h00});
      for (int c = 0; c < 12; c++) begin
         step();
         ve_i = (c < 8);
         {red_i, green_i, blue_i} = line_rgb[c % 8];
         if (c == 4) begin
            @(negedge clk);
            #1;
            rst = 1'b1;
            #1;
            check("async_wr_data", wr_data_o, 32'h0);
            check("async_wr_en", 32'(wr_en_o), 32'h0);
            check("async_hres", 32'(hres_meas_o), 32'h0);
            check("async_vres", 32'(vres_meas_o), 32'h0);
            check("async_state", 32'(state_o), 32'h0);
            check("async_flags", {29'd0, frame_start_o, line_end_o, overflow_o}, 32'h0);
            mdl_state = 1; mdl_ovf = 0; mdl_hres = 0;
         end
         if (c == 11) rst = 1'b0;
      end
      fill_line(4); drive_line(4, 0);
      check("post_reset_waiting", 32'(state_o), 32'h1);
      drive_vsync();
      fill_line(4); drive_line(4, 0);

      repeat (5) step();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("frame_start_count", 32'(n_fs), 32'(exp_fs));
      check("line_end_count", 32'(n_le), 32'(exp_le));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
